// File: rtl/aemb_dwb_seq.sv
// aeMB data-bus sequencer: turns one decoded load/store into a single Wishbone
// data cycle, stalling the pipeline until ack or bus timeout.
module aemb_dwb_seq #(
    parameter int TMO  = 16,
    parameter int TMOW = 8
) (
    input  logic        nclk,
    input  logic        nrst,
    input  logic [1:0]  rLDST,
    input  logic [1:0]  rSIZE,
    input  logic [31:0] rADR,
    input  logic [31:0] rDAT,
    input  logic        dwb_ack_i,
    input  logic [31:0] dwb_dat_i,
    output logic [31:0] dwb_adr_o,
    output logic [31:0] dwb_dat_o,
    output logic [3:0]  dwb_sel_o,
    output logic        dwb_stb_o,
    output logic        dwb_we_o,
    output logic [31:0] rDWBDAT,
    output logic        drun,
    output logic        dbe_o,
    output logic        dma_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TMO - 1);

    state_t            state_q, state_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic [3:0]        sel_q, sel_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [31:0]       rdw_q, rdw_d;
    logic              dbe_q, dbe_d;
    logic              dma_q, dma_d;
    logic [TMOW-1:0]   cnt_q, cnt_d;

    logic              req;
    logic              is_store;
    logic              size_byte;
    logic              size_half;
    logic              mis;
    logic              tmo_hit;
    logic [3:0]        sel_req;
    logic [31:0]       st_dat;

    // Reserved encodings fold onto "none" (rLDST) and "word" (rSIZE).
    assign req       = (rLDST == 2'b01) || (rLDST == 2'b10);
    assign is_store  = (rLDST == 2'b10);
    assign size_byte = (rSIZE == 2'b00);
    assign size_half = (rSIZE == 2'b01);
    assign mis       = req && ((size_half && rADR[0]) ||
                               (!size_byte && !size_half && (rADR[1:0] != 2'b00)));
    assign tmo_hit   = (TMO != 0) && (cnt_q == TMO_LAST);

    // Lane gi carries byte offset gi: big-endian, so offset 0 is sel bit 3
    // and occupies data bits [31:24].
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign sel_req[3-gi] = size_byte ? (rADR[1:0] == 2'(gi)) :
                                   size_half ? (rADR[1] == (gi >= 2)) :
                                               1'b1;
            assign st_dat[8*gi +: 8] = size_byte ? rDAT[7:0] :
                                       size_half ? rDAT[8*(gi%2) +: 8] :
                                                   rDAT[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        stb_d   = stb_q;
        we_d    = we_q;
        rdw_d   = rdw_q;
        cnt_d   = cnt_q;
        dbe_d   = 1'b0;
        dma_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (mis) begin
                        dma_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                        adr_d   = {rADR[31:2], 2'b00};
                        we_d    = is_store;
                        sel_d   = sel_req;
                        stb_d   = 1'b1;
                        cnt_d   = '0;
                        // Loads leave the previous store data on the bus.
                        if (is_store) begin
                            dat_d = st_dat;
                        end
                    end
                end
            end
            BUSY: begin
                if (dwb_ack_i) begin
                    state_d = ACK;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'b0000;
                    if (!we_q) begin
                        rdw_d = dwb_dat_i;
                    end
                end else if (tmo_hit) begin
                    state_d = ACK;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'b0000;
                    dbe_d   = 1'b1;
                    if (!we_q) begin
                        rdw_d = '0;
                    end
                end else if (cnt_q != {TMOW{1'b1}}) begin
                    // Saturate so an unbounded wait (TMO=0) never wraps.
                    cnt_d = cnt_q + TMOW'(1);
                end
            end
            ACK: begin
                // The request that caused this access is still on the inputs;
                // skipping it here is what prevents a reissue.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(negedge nclk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            rdw_q   <= '0;
            dbe_q   <= 1'b0;
            dma_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            rdw_q   <= rdw_d;
            dbe_q   <= dbe_d;
            dma_q   <= dma_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall from the issue cycle through the last BUSY cycle; ACK lets the
    // pipeline advance exactly once.
    assign drun = !(state_q == BUSY) && !((state_q == IDLE) && req && !mis);

    assign dwb_adr_o = adr_q;
    assign dwb_dat_o = dat_q;
    assign dwb_sel_o = sel_q;
    assign dwb_stb_o = stb_q;
    assign dwb_we_o  = we_q;
    assign rDWBDAT   = rdw_q;
    assign dbe_o     = dbe_q;
    assign dma_o     = dma_q;

endmodule
